// File: rtl/wmst_out_fm_ctrl.sv
// Write-master controller: streams one output feature-map tile from the store FIFO
// to external memory, one burst per tile row, with extents clamped at map edges.
module wmst_out_fm_ctrl #(
  parameter int CW          = 16,
  parameter int XAW         = 32,
  parameter int M           = 32,
  parameter int R           = 64,
  parameter int C           = 32,
  parameter int Tm          = 16,
  parameter int Tr          = 64,
  parameter int Tc          = 16,
  parameter int OUT_FM_BASE = 131072
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            store_start,
  output logic            store_done,
  output logic            busy,
  output logic [XAW-1:0]  param_waddr,
  output logic [CW-1:0]   param_iolen,
  output logic            store_trans_start,
  input  logic            store_trans_done,
  input  logic [CW-1:0]   store_fifo_cnt,
  input  logic [CW-1:0]   tile_base_m,
  input  logic [CW-1:0]   tile_base_row,
  input  logic [CW-1:0]   tile_base_col
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CONFIG = 3'd2,
    S_TRANS  = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [CW-1:0]  ZERO_C   = CW'(0);
  localparam logic [CW-1:0]  DIM_M    = CW'(M);
  localparam logic [CW-1:0]  DIM_R    = CW'(R);
  localparam logic [CW-1:0]  DIM_C    = CW'(C);
  localparam logic [CW-1:0]  TILE_M   = CW'(Tm);
  localparam logic [CW-1:0]  TILE_R   = CW'(Tr);
  localparam logic [CW-1:0]  TILE_C   = CW'(Tc);
  localparam logic [XAW-1:0] PLANE_W  = XAW'(R * C);
  localparam logic [XAW-1:0] ROW_W    = XAW'(C);
  localparam logic [XAW-1:0] BASE_W   = XAW'(OUT_FM_BASE);

  // A base at or past its dimension yields an empty extent.
  function automatic logic [CW-1:0] clamp_ext(
    input logic [CW-1:0] base,
    input logic [CW-1:0] dim,
    input logic [CW-1:0] tile
  );
    logic [CW-1:0] rem;
    if (base >= dim) begin
      clamp_ext = ZERO_C;
    end else begin
      rem = dim - base;
      clamp_ext = (rem < tile) ? rem : tile;
    end
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   base_m_q, base_m_d;
  logic [CW-1:0]   base_row_q, base_row_d;
  logic [CW-1:0]   base_col_q, base_col_d;
  logic [CW-1:0]   row_len_q, row_len_d;
  logic [CW-1:0]   n_rows_q, n_rows_d;
  logic [CW-1:0]   n_maps_q, n_maps_d;
  logic [CW-1:0]   tr_q, tr_d;
  logic [CW-1:0]   tm_q, tm_d;
  logic [XAW-1:0]  waddr_q, waddr_d;
  logic [CW-1:0]   iolen_q, iolen_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            tstart_q, tstart_d;

  logic [CW-1:0]   row_len_s, n_rows_s, n_maps_s;
  logic [XAW-1:0]  map_idx_s, row_idx_s, word_addr_s;
  logic            last_row_s, last_map_s;

  // Extents of the tile being offered and burst address of the current row.
  always_comb begin
    row_len_s   = clamp_ext(tile_base_col, DIM_C, TILE_C);
    n_rows_s    = clamp_ext(tile_base_row, DIM_R, TILE_R);
    n_maps_s    = clamp_ext(tile_base_m,   DIM_M, TILE_M);
    map_idx_s   = XAW'(base_m_q) + XAW'(tm_q);
    row_idx_s   = XAW'(base_row_q) + XAW'(tr_q);
    word_addr_s = BASE_W + (map_idx_s * PLANE_W) + (row_idx_s * ROW_W) + XAW'(base_col_q);
    last_row_s  = (tr_q == (n_rows_q - ONE_C));
    last_map_s  = (tm_q == (n_maps_q - ONE_C));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    base_m_d   = base_m_q;
    base_row_d = base_row_q;
    base_col_d = base_col_q;
    row_len_d  = row_len_q;
    n_rows_d   = n_rows_q;
    n_maps_d   = n_maps_q;
    tr_d       = tr_q;
    tm_d       = tm_q;
    waddr_d    = waddr_q;
    iolen_d    = iolen_q;
    case (state_q)
      S_IDLE: begin
        if (store_start) begin
          base_m_d   = tile_base_m;
          base_row_d = tile_base_row;
          base_col_d = tile_base_col;
          row_len_d  = row_len_s;
          n_rows_d   = n_rows_s;
          n_maps_d   = n_maps_s;
          tr_d       = ZERO_C;
          tm_d       = ZERO_C;
          if ((row_len_s == ZERO_C) || (n_rows_s == ZERO_C) || (n_maps_s == ZERO_C)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (store_fifo_cnt >= row_len_q) begin
          state_d = S_CONFIG;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CONFIG: begin
        waddr_d = word_addr_s << 2;
        iolen_d = row_len_q;
        state_d = S_TRANS;
      end
      S_TRANS: begin
        if (store_trans_done) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_TRANS;
        end
      end
      S_NEXT: begin
        if (last_row_s && last_map_s) begin
          state_d = S_FINISH;
        end else if (last_row_s) begin
          tr_d    = ZERO_C;
          tm_d    = tm_q + ONE_C;
          state_d = S_WAIT;
        end else begin
          tr_d    = tr_q + ONE_C;
          state_d = S_WAIT;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are registered copies of where the FSM is heading.
    done_d   = (state_d == S_FINISH);
    busy_d   = (state_d != S_IDLE);
    tstart_d = (state_q == S_CONFIG);
  end

  // State, context and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_m_q   <= ZERO_C;
      base_row_q <= ZERO_C;
      base_col_q <= ZERO_C;
      row_len_q  <= ZERO_C;
      n_rows_q   <= ZERO_C;
      n_maps_q   <= ZERO_C;
      tr_q       <= ZERO_C;
      tm_q       <= ZERO_C;
      waddr_q    <= {XAW{1'b0}};
      iolen_q    <= ZERO_C;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      tstart_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_m_q   <= base_m_d;
      base_row_q <= base_row_d;
      base_col_q <= base_col_d;
      row_len_q  <= row_len_d;
      n_rows_q   <= n_rows_d;
      n_maps_q   <= n_maps_d;
      tr_q       <= tr_d;
      tm_q       <= tm_d;
      waddr_q    <= waddr_d;
      iolen_q    <= iolen_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tstart_q   <= tstart_d;
    end
  end

  assign store_done        = done_q;
  assign busy              = busy_q;
  assign param_waddr       = waddr_q;
  assign param_iolen       = iolen_q;
  assign store_trans_start = tstart_q;

endmodule

// File: doc/wmst_out_fm_ctrl.md
# wmst_out_fm_ctrl

Write-master controller that stores one output feature-map tile from the on-chip store FIFO to external memory. It sits between the convolution core's output store FIFO and the Avalon write master. It issues one burst per tile row, covering every row of every output map in the tile. Each burst is gated on the FIFO holding a full row, and row length and counts are clamped at feature-map edges.

## Interface
- CW, 16, counter/length width
- XAW, 32, external byte-address width
- M, 32, output maps total
- R, 64, output rows total
- C, 32, output columns total
- Tm, 16, tile maps
- Tr, 64, tile rows
- Tc, 16, tile columns
- OUT_FM_BASE, 131072, output map base (word address)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- store_start  in  1  start tile store; sampled only in IDLE
- store_done  out  1  one-cycle pulse: whole tile written
- busy  out  1  high whenever state != IDLE
- param_waddr  out  XAW  burst byte address
- param_iolen  out  CW  burst length in words
- store_trans_start  out  1  one-cycle pulse to write master
- store_trans_done  in  1  write master finished current burst
- store_fifo_cnt  in  CW  words currently in store FIFO
- tile_base_m, tile_base_row, tile_base_col  in  CW each  tile origin; latched on start acceptance

## Operation
- On accept (IDLE & store_start): latch bases and compute extents, each registered:
  - row_len = min(Tc, C-base_col)
  - n_rows = min(Tr, R-base_row)
  - n_maps = min(Tm, M-base_m)
  - Clear tr, tm.
- A base at or beyond its dimension gives extent 0: no bursts are issued and the block goes to FINISH.
- States IDLE, WAIT, CONFIG, TRANS, NEXT, FINISH:
  - IDLE: store_start -> WAIT, or -> FINISH if any extent is 0.
  - WAIT: store_fifo_cnt >= row_len -> CONFIG; otherwise hold.
  - CONFIG: register param_waddr and param_iolen = row_len; -> TRANS.
  - TRANS: store_trans_done -> NEXT.
  - NEXT: if tr==n_rows-1 and tm==n_maps-1 -> FINISH. Otherwise advance tr (wrapping to 0 and incrementing tm) -> WAIT.
  - FINISH: -> IDLE; store_done pulses high during this cycle.
- Address: param_waddr = (OUT_FM_BASE + (base_m+tm)*R*C + (base_row+tr)*C + base_col) << 2, computed at XAW width and truncated.
- Row order: tr is the inner loop and tm the outer loop, so addresses ascend within a map.
- store_trans_done outside TRANS is ignored.
- store_start outside IDLE is ignored; the latched bases stay unchanged.
- FIFO underflow is never possible: a burst starts only if the full row is present.

## Timing
- Reset values: store_done=0, busy=0, param_waddr=0, param_iolen=0, store_trans_start=0, state IDLE, counters 0.
- store_trans_start is registered and high for exactly the first TRANS cycle.
- param_waddr and param_iolen become valid on the CONFIG->TRANS edge and hold until the next CONFIG.
- Minimum burst-to-burst spacing: TRANS(done) -> NEXT -> WAIT -> CONFIG -> TRANS, so at least 4 cycles between trans_start pulses when the FIFO is ready.
- Start latency: store_start edge -> WAIT -> CONFIG -> first trans_start, 3 cycles with a full FIFO.
- store_done occurs 2 cycles after the final store_trans_done (NEXT, then FINISH).
- Extent 0: store_done occurs 1 cycle after start acceptance.
- store_done and the next store_start may share no cycle; a start is accepted only once back in IDLE.
- Reset mid-operation aborts immediately. There is no done pulse, and the in-flight burst is the write master's responsibility.

## Test plan
- Defaults, bases (0,0,0), FIFO always >= 16, trans_done 5 cycles after start:
  - Exactly 1024 bursts, all iolen=16.
  - First waddr=524288, second 524416, last (tm=15, tr=63) = (131072+15*2048+63*32)*4 = 655232.
  - One store_done.
- Edge tile, bases (16,0,24): iolen=8 on every burst, 16*64=1024 bursts, first waddr=(131072+16*2048+24)*4=655456.
- Map clamp, bases (24,32,0): n_maps=8, n_rows=32 -> 256 bursts, then store_done.
- FIFO starvation: store_fifo_cnt=15 for 20 cycles, then 16 -> no trans_start while cnt=15; trans_start 2 cycles after cnt reaches 16.
- Spurious inputs and reset:
  - trans_done pulsed in WAIT, and store_start pulsed mid-tile -> no state or counter change.
  - rst asserted during TRANS of burst 3 -> all outputs 0 the same cycle.
  - A new start then begins at the tile's first address.
- Out-of-range, base_col=32 -> zero bursts, store_done 1 cycle after accept.
